// File: rtl/lfsr32_checker.sv
// lfsr32_checker
//
// Receive-side checker for the 32-bit XNOR LFSR sample source. It seeds itself
// from the incoming stream, confirms the stream is a valid successor chain
// (VERIFY), then tracks it while locked. Mismatches while locked are
// flagged and counted. The reference flywheels through them, so an isolated
// corrupted word does not break lock.
//
// Optional feature: define LFSR32_CHECK_LOCKUP_EN to detect the all-ones
// XNOR lockup word. When it is defined, a sticky `lockup` flag is set and
// all-ones words are refused as seeds. Without the macro, `lockup` is tied to 0.
//
// Ports:
//   clk           system clock, rising edge
//   reset         asynchronous active-high reset
//   din_valid     din carries a sample this cycle
//   din [31:0]    sample word (full generator register state)
//   clear_counts  synchronous clear of error_count and word_count
//   locked        checker is in the LOCKED state
//   error         one-cycle pulse per counted mismatch
//   error_count   saturating count of mismatches while locked
//   word_count    saturating count of samples checked while locked
//   lockup        sticky all-ones detect (macro builds only, else 0)

module lfsr32_checker #(
    parameter int unsigned LOCK_COUNT = 4,
    parameter int unsigned LOSS_COUNT = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        din_valid,
    input  logic [31:0] din,
    input  logic        clear_counts,
    output logic        locked,
    output logic        error,
    output logic [31:0] error_count,
    output logic [31:0] word_count,
    output logic        lockup
);

    typedef enum logic [1:0] {
        StAcquire,
        StVerify,
        StLocked
    } state_e;

    // Counter values seen just before the transition-causing increment.
    localparam logic [3:0] LockLast = 4'(LOCK_COUNT - 1);
    localparam logic [3:0] LossLast = 4'(LOSS_COUNT - 1);

    function automatic logic [31:0] lfsr_next(input logic [31:0] r);
        return {r[30:0], ~(r[31] ^ r[21] ^ r[1] ^ r[0])};
    endfunction

    state_e      state;
    logic [31:0] ref_word;
    logic [3:0]  match_cnt;
    logic [3:0]  miss_cnt;

    logic [31:0] ref_next;
    logic        din_match;
    logic        seed_block;

    assign ref_next  = lfsr_next(ref_word);
    assign din_match = (din == ref_next);

`ifdef LFSR32_CHECK_LOCKUP_EN
    logic din_ones;
    assign din_ones   = (din == 32'hFFFF_FFFF);
    // A stuck all-ones stream is its own successor and would lock trivially.
    assign seed_block = din_ones;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lockup <= 1'b0;
        end else if (din_valid && din_ones) begin
            lockup <= 1'b1;
        end
    end
`else
    assign seed_block = 1'b0;
    assign lockup     = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= StAcquire;
            ref_word    <= 32'h0;
            match_cnt   <= 4'h0;
            miss_cnt    <= 4'h0;
            locked      <= 1'b0;
            error       <= 1'b0;
            error_count <= 32'h0;
            word_count  <= 32'h0;
        end else begin
            error <= 1'b0;
            if (din_valid) begin
                unique case (state)
                    StAcquire: begin
                        if (!seed_block) begin
                            ref_word  <= din;
                            match_cnt <= 4'h0;
                            state     <= StVerify;
                        end
                    end
                    StVerify: begin
                        if (seed_block) begin
                            match_cnt <= 4'h0;
                            state     <= StAcquire;
                        end else if (din_match) begin
                            ref_word  <= din;
                            match_cnt <= match_cnt + 4'h1;
                            if (match_cnt == LockLast) begin
                                state    <= StLocked;
                                locked   <= 1'b1;
                                miss_cnt <= 4'h0;
                            end
                        end else begin
                            // Reseed from the new word and start counting again.
                            ref_word  <= din;
                            match_cnt <= 4'h0;
                        end
                    end
                    StLocked: begin
                        if (word_count != 32'hFFFF_FFFF) begin
                            word_count <= word_count + 32'h1;
                        end
                        if (din_match) begin
                            ref_word <= din;
                            miss_cnt <= 4'h0;
                        end else begin
                            error <= 1'b1;
                            if (error_count != 32'hFFFF_FFFF) begin
                                error_count <= error_count + 32'h1;
                            end
                            // Flywheel: advance the prediction, never trust the bad word.
                            ref_word <= ref_next;
                            miss_cnt <= miss_cnt + 4'h1;
                            if (miss_cnt == LossLast) begin
                                state  <= StAcquire;
                                locked <= 1'b0;
                            end
                        end
                    end
                    default: begin
                        state  <= StAcquire;
                        locked <= 1'b0;
                    end
                endcase
            end
            // Placed last so a coincident increment loses to the clear.
            if (clear_counts) begin
                error_count <= 32'h0;
                word_count  <= 32'h0;
            end
        end
    end

endmodule
